// File: rtl/fan_ctrl_pkg.sv
// Shared types and constants for the fan board controller: FSM states,
// level-to-duty mapping and off-timer presets.
package fan_ctrl_pkg;

  typedef logic [1:0] level_t;

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_RAMP     = 2'd1,
    ST_RUN      = 2'd2,
    ST_SPINDOWN = 2'd3
  } fan_state_t;

  localparam logic [7:0] DUTY_L0 = 8'd0;
  localparam logic [7:0] DUTY_L1 = 8'd64;
  localparam logic [7:0] DUTY_L2 = 8'd128;
  localparam logic [7:0] DUTY_L3 = 8'd255;

  localparam logic [8:0] TMR_P0 = 9'd0;
  localparam logic [8:0] TMR_P1 = 9'd60;
  localparam logic [8:0] TMR_P2 = 9'd180;
  localparam logic [8:0] TMR_P3 = 9'd300;

  function automatic logic [7:0] level_duty(input level_t lvl);
    case (lvl)
      2'd0:    level_duty = DUTY_L0;
      2'd1:    level_duty = DUTY_L1;
      2'd2:    level_duty = DUTY_L2;
      default: level_duty = DUTY_L3;
    endcase
  endfunction

  function automatic logic [8:0] timer_preset(input level_t sel);
    case (sel)
      2'd0:    timer_preset = TMR_P0;
      2'd1:    timer_preset = TMR_P1;
      2'd2:    timer_preset = TMR_P2;
      default: timer_preset = TMR_P3;
    endcase
  endfunction

endpackage

// File: rtl/fan_tick_gen.sv
// Ramp and seconds prescalers. The ramp prescaler exists only when
// FAN_SOFTSTART_EN is defined; the seconds prescaler restarts on sec_restart.
module fan_tick_gen #(
  parameter int unsigned RAMP_STEP_CYC = 100_000,
  parameter int unsigned TICK_CYC      = 100_000_000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic sec_restart,
  output logic ramp_tick,
  output logic sec_tick
);

  localparam int unsigned SW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  logic [SW-1:0] sec_cnt;

  assign sec_tick = (sec_cnt == SW'(TICK_CYC - 1));

  always_ff @(posedge clk) begin
    if (!reset_p || sec_restart || sec_tick) sec_cnt <= '0;
    else                                     sec_cnt <= sec_cnt + 1'b1;
  end

`ifdef FAN_SOFTSTART_EN
  localparam int unsigned RW = (RAMP_STEP_CYC > 1) ? $clog2(RAMP_STEP_CYC) : 1;

  logic [RW-1:0] ramp_cnt;

  // Free-running from reset; target changes do not realign it.
  assign ramp_tick = (ramp_cnt == RW'(RAMP_STEP_CYC - 1));

  always_ff @(posedge clk) begin
    if (!reset_p || ramp_tick) ramp_cnt <= '0;
    else                       ramp_cnt <= ramp_cnt + 1'b1;
  end
`else
  // No ramp prescaler: duty jumps straight to target, so no ramp tick is needed.
  assign ramp_tick = (RAMP_STEP_CYC == 0);
`endif

endmodule

// File: rtl/fan_mode_ctrl.sv
// Fan board mode controller: buttons -> speed/LED/timer levels, fan duty FSM.
// Define FAN_SOFTSTART_EN for ramped duty; otherwise duty follows target at once.
module fan_mode_ctrl
  import fan_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned RAMP_STEP_CYC = 100_000,
  parameter int unsigned TICK_CYC      = 100_000_000
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       btn_speed,
  input  logic       btn_led,
  input  logic       btn_timer,
  input  logic       btn_stop,
  output logic [7:0] fan_duty,
  output logic [7:0] led_duty,
  output logic [1:0] speed_level,
  output logic [1:0] timer_sel,
  output logic [8:0] timer_sec,
  output logic       timeout,
  output logic       fan_busy
);

`ifdef FAN_SOFTSTART_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  // A zero tick count falls back to one second at the system clock.
  localparam int unsigned SEC_DIV = (TICK_CYC != 0) ? TICK_CYC : CLK_HZ;

  fan_state_t state;
  level_t     led_level;
  logic [7:0] target;
  logic       ramp_tick, sec_tick;
  logic       count_en, expire, load, sec_restart;

  assign target      = level_duty(speed_level);
  assign count_en    = (timer_sel != 2'd0) && (speed_level != 2'd0);
  assign expire      = sec_tick && count_en && (timer_sec == 9'd1);
  assign load        = btn_timer && !btn_stop && !expire;
  // Holding the prescaler while paused makes resumption start a full second.
  assign sec_restart = load || !count_en;

  fan_tick_gen #(
    .RAMP_STEP_CYC (RAMP_STEP_CYC),
    .TICK_CYC      (SEC_DIV)
  ) u_tick (
    .clk         (clk),
    .reset_p     (reset_p),
    .sec_restart (sec_restart),
    .ramp_tick   (ramp_tick),
    .sec_tick    (sec_tick)
  );

  always_ff @(posedge clk) begin
    if (!reset_p || btn_stop) begin
      speed_level <= 2'd0;
      led_level   <= 2'd0;
      led_duty    <= 8'd0;
      timer_sel   <= 2'd0;
      timer_sec   <= 9'd0;
      timeout     <= 1'b0;
    end else if (expire) begin
      speed_level <= 2'd0;
      led_level   <= 2'd0;
      led_duty    <= 8'd0;
      timer_sel   <= 2'd0;
      timer_sec   <= 9'd0;
      timeout     <= 1'b1;
    end else begin
      timeout <= 1'b0;
      if (btn_speed) speed_level <= speed_level + 2'd1;
      if (btn_led) begin
        led_level <= led_level + 2'd1;
        led_duty  <= level_duty(led_level + 2'd1);
      end
      if (btn_timer) begin
        timer_sel <= timer_sel + 2'd1;
        timer_sec <= timer_preset(timer_sel + 2'd1);
      end else if (sec_tick && count_en && timer_sec != 9'd0) begin
        timer_sec <= timer_sec - 9'd1;
      end
    end
  end

  // Without soft start every move into RAMP/SPINDOWN lands duty on target.
  always_ff @(posedge clk) begin
    if (!reset_p || btn_stop) begin
      state    <= ST_OFF;
      fan_duty <= 8'd0;
      fan_busy <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          fan_duty <= 8'd0;
          if (target != 8'd0) begin
            state    <= ST_RAMP;
            fan_busy <= 1'b1;
            if (!SOFT) fan_duty <= target;
          end
        end
        ST_RAMP: begin
          if (target < fan_duty) begin
            state    <= ST_SPINDOWN;
            fan_busy <= 1'b1;
            if (!SOFT) fan_duty <= target;
          end else if (target == fan_duty) begin
            state    <= (target != 8'd0) ? ST_RUN : ST_OFF;
            fan_busy <= 1'b0;
          end else if (!SOFT) begin
            fan_duty <= target;
          end else if (ramp_tick) begin
            fan_duty <= fan_duty + 8'd1;
          end
        end
        ST_RUN: begin
          if (target != fan_duty) begin
            state    <= (target > fan_duty) ? ST_RAMP : ST_SPINDOWN;
            fan_busy <= 1'b1;
            if (!SOFT) fan_duty <= target;
          end
        end
        ST_SPINDOWN: begin
          if (target > fan_duty) begin
            state    <= ST_RAMP;
            fan_busy <= 1'b1;
            if (!SOFT) fan_duty <= target;
          end else if (target == fan_duty) begin
            state    <= (target != 8'd0) ? ST_RUN : ST_OFF;
            fan_busy <= 1'b0;
          end else if (!SOFT) begin
            fan_duty <= target;
          end else if (ramp_tick) begin
            fan_duty <= fan_duty - 8'd1;
          end
        end
        default: begin
          state    <= ST_OFF;
          fan_duty <= 8'd0;
          fan_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fan_mode_ctrl.sv
// Directed bench for fan_mode_ctrl; expectations follow FAN_SOFTSTART_EN if defined.
module tb_fan_mode_ctrl;
  import fan_ctrl_pkg::*;

  localparam int unsigned RAMP = 4;
  localparam int unsigned TICK = 10;

  logic       clk = 1'b0;
  logic       reset_p = 1'b0;
  logic       btn_speed = 1'b0, btn_led = 1'b0, btn_timer = 1'b0, btn_stop = 1'b0;
  logic [7:0] fan_duty, led_duty;
  logic [1:0] speed_level, timer_sel;
  logic [8:0] timer_sec;
  logic       timeout, fan_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fan_mode_ctrl #(
    .CLK_HZ        (100_000_000),
    .RAMP_STEP_CYC (RAMP),
    .TICK_CYC      (TICK)
  ) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .btn_speed   (btn_speed),
    .btn_led     (btn_led),
    .btn_timer   (btn_timer),
    .btn_stop    (btn_stop),
    .fan_duty    (fan_duty),
    .led_duty    (led_duty),
    .speed_level (speed_level),
    .timer_sel   (timer_sel),
    .timer_sec   (timer_sec),
    .timeout     (timeout),
    .fan_busy    (fan_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; pulses for one posedge and returns at the next negedge.
  task automatic press(input logic s, input logic l, input logic t, input logic p);
    btn_speed = s; btn_led = l; btn_timer = t; btn_stop = p;
    @(negedge clk);
    btn_speed = 1'b0; btn_led = 1'b0; btn_timer = 1'b0; btn_stop = 1'b0;
  endtask

  // Entered one negedge after the FSM left OFF/RUN; follows duty to 'to'.
  task automatic ramp_to(input logic [7:0] to);
    int         cyc;
    int         last;
    logic [7:0] prev;
`ifdef FAN_SOFTSTART_EN
    prev = fan_duty;
    cyc  = 0;
    last = -1;
    while (fan_duty != to && cyc < 260 * RAMP) begin
      @(negedge clk);
      cyc++;
      if (fan_duty != prev) begin
        chk("ramp_step", fan_duty, (to > prev) ? prev + 8'd1 : prev - 8'd1);
        if (last >= 0) chk("ramp_gap", cyc - last, RAMP);
        else           chk("ramp_first_within", (cyc <= RAMP), 1);
        last = cyc;
        prev = fan_duty;
      end
    end
`else
    cyc = 0; last = 0; prev = 8'd0;
`endif
    chk("duty_final", fan_duty, to);
    @(negedge clk);
    chk("busy_off", fan_busy, 0);
    chk("state_end", dut.state, (to == 8'd0) ? ST_OFF : ST_RUN);
  endtask

  task automatic settle(input logic [7:0] to);
    @(negedge clk);
    chk("busy_on", fan_busy, 1);
    ramp_to(to);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_duty"},  fan_duty, 0);
    chk({tag, "_led"},   led_duty, 0);
    chk({tag, "_level"}, speed_level, 0);
    chk({tag, "_sel"},   timer_sel, 0);
    chk({tag, "_sec"},   timer_sec, 0);
    chk({tag, "_tmo"},   timeout, 0);
    chk({tag, "_busy"},  fan_busy, 0);
    chk({tag, "_state"}, dut.state, ST_OFF);
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_p = 1'b1;

    // Soft start to level 1
    press(1, 0, 0, 0);
    chk("t1_level", speed_level, 1);
    settle(8'd64);

    // Up to level 3, then wrap to 0 and spin down
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    chk("t2_level3", speed_level, 3);
    settle(8'd255);
    press(1, 0, 0, 0);
    chk("t2_wrap", speed_level, 0);
    settle(8'd0);

    // Timer expiry at 180 s with a speed press on the expiry cycle
    press(1, 0, 0, 0);
    settle(8'd64);
    press(0, 1, 0, 0);
    chk("t3_led", led_duty, 64);
    press(0, 0, 1, 0);
    chk("t3_sel1", timer_sel, 1);
    chk("t3_sec60", timer_sec, 60);
    press(0, 0, 1, 0);
    chk("t3_sel2", timer_sel, 2);
    chk("t3_sec180", timer_sec, 180);
    repeat (TICK - 1) @(negedge clk);
    chk("t3_hold", timer_sec, 180);
    @(negedge clk);
    chk("t3_first_dec", timer_sec, 179);
    for (int k = 178; k >= 1; k--) begin
      repeat (TICK) @(negedge clk);
      chk("t3_count", timer_sec, k);
    end
    repeat (TICK - 1) @(negedge clk);
    chk("t3_pre_sec", timer_sec, 1);
    chk("t3_pre_tmo", timeout, 0);
    press(1, 0, 0, 0);
    chk("t3_tmo", timeout, 1);
    chk("t3_sec0", timer_sec, 0);
    chk("t3_level0", speed_level, 0);
    chk("t3_sel0", timer_sel, 0);
    chk("t3_led0", led_duty, 0);
    @(negedge clk);
    chk("t3_tmo_once", timeout, 0);
    chk("t3_press_dropped", speed_level, 0);
    chk("t3_spindown", dut.state, ST_SPINDOWN);
    ramp_to(8'd0);

    // Timer holds while fan is off; countdown starts with the fan
    press(0, 0, 1, 0);
    chk("t4_sel", timer_sel, 1);
    chk("t4_sec", timer_sec, 60);
    repeat (1000) @(negedge clk);
    chk("t4_held", timer_sec, 60);
    press(1, 0, 0, 0);
    chk("t4_level", speed_level, 1);
    repeat (TICK - 1) @(negedge clk);
    chk("t4_not_yet", timer_sec, 60);
    @(negedge clk);
    chk("t4_first_dec", timer_sec, 59);

    // Stop beats a simultaneous speed press
    press(0, 1, 0, 0);
    chk("t5_led", led_duty, 64);
    press(1, 0, 0, 1);
    chk_all_zero("t5_stop");

    // Reset in the middle of a ramp and a countdown
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    chk("t6_level2", speed_level, 2);
`ifdef FAN_SOFTSTART_EN
    w = 0;
    while (fan_duty != 8'd30 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("t6_reach30", fan_duty, 30);
`else
    w = 0;
    @(negedge clk);
    chk("t6_jump128", fan_duty, 128);
`endif
    chk("t6_counting", (timer_sec != 9'd0), 1);
    reset_p = 1'b0;
    @(negedge clk);
    reset_p = 1'b1;
    chk_all_zero("t6_reset");
    press(1, 0, 0, 0);
    chk("t6_after_reset", speed_level, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
